instr_exec: RTL and testbench

- PDP-8 instruction execution unit; consumes the decode structs (pdp_mem_opcode_s, pdp_op7_opcode_s) produced by the fetch/decode stage and reports PC_value back to it.
- Uses the stall handshake: stall is high while an instruction executes and low when the unit can accept the next one.
- Owns the AC, Link and PC registers and a simple single-port memory request interface.
- Indirect addressing and auto-increment are resolved upstream; the address field is always the effective address.

---
 rtl/instr_exec.sv | 186 ++++++++++++++++++
 tb/tb_instr_exec.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec.sv
// PDP-8 execution unit: runs one decoded memory-reference or group-1/2 operate
// instruction at a time, owning AC, Link and PC and a single-port memory interface.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package instr_exec_pkg;
  typedef struct packed {
    logic AND, TAD, ISZ, DCA, JMS, JMP;
    logic [`ADDR_WIDTH-1:0] addr;
  } pdp_mem_opcode_s;

  // first member is bit 21 (NOP), last is bit 0 (CLA2)
  typedef struct packed {
    logic NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA1;
    logic CLA_CLL, HLT, OSR, SKP, SNL, SZL, SZA, SNA, SMA, SPA, CLA2;
  } pdp_op7_opcode_s;
endpackage

module instr_exec
  import instr_exec_pkg::*;
#(
  parameter int ADDR_W = `ADDR_WIDTH,
  parameter int DATA_W = `DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] base_addr,
  input  pdp_mem_opcode_s   pdp_mem_opcode,
  input  pdp_op7_opcode_s   pdp_op7_opcode,
  output logic              stall,
  output logic [ADDR_W-1:0] PC_value,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] ac_value,
  output logic              link_value,
  output logic              halted,
  output logic              illegal_op
);
  localparam int OPS_W = 6 + $bits(pdp_op7_opcode_s);

  typedef enum logic [2:0] {IDLE, RD, USE, WR, EXEC, HALT, WAIT_CLEAR} state_e;

  state_e          state, state_nxt;
  pdp_mem_opcode_s mem_q;
  pdp_op7_opcode_s op7_q;
  logic            illegal_q;
  logic [DATA_W-1:0] ac, wdata, ac_n;
  logic              link, l_n, skip;
  logic [ADDR_W-1:0] pc, pc_inc, pc_skip;
  logic [OPS_W-1:0]  ops;
  logic              any_op, multi_op;
  logic [DATA_W:0]   tad_sum, iac_sum;

  assign ops = {pdp_mem_opcode.AND, pdp_mem_opcode.TAD, pdp_mem_opcode.ISZ,
                pdp_mem_opcode.DCA, pdp_mem_opcode.JMS, pdp_mem_opcode.JMP,
                pdp_op7_opcode};
  assign any_op   = |ops;
  assign multi_op = |(ops & (ops - OPS_W'(1)));

  assign pc_inc  = pc + ADDR_W'(1);
  assign pc_skip = pc + ADDR_W'(2);
  assign tad_sum = {1'b0, ac} + {1'b0, mem_rd_data};
  assign iac_sum = {1'b0, ac} + (DATA_W+1)'(1);

  assign stall       = state inside {RD, USE, WR, EXEC, HALT};
  assign mem_rd_req  = (state == RD);
  assign mem_wr_req  = (state == WR);
  assign mem_rd_addr = mem_q.addr;
  assign mem_wr_addr = mem_q.addr;
  assign mem_wr_data = wdata;
  assign illegal_op  = (state == EXEC) && illegal_q;
  assign PC_value    = pc;
  assign ac_value    = ac;
  assign link_value  = link;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_op) begin
        if (multi_op)                                                    state_nxt = EXEC;
        else if (pdp_mem_opcode.AND | pdp_mem_opcode.TAD | pdp_mem_opcode.ISZ) state_nxt = RD;
        else if (pdp_mem_opcode.DCA | pdp_mem_opcode.JMS)                state_nxt = WR;
        else                                                             state_nxt = EXEC;
      end
      RD:         state_nxt = USE;
      USE:        state_nxt = mem_q.ISZ ? WR : WAIT_CLEAR;
      WR:         state_nxt = WAIT_CLEAR;
      EXEC:       state_nxt = (op7_q.HLT && !illegal_q) ? HALT : WAIT_CLEAR;
      HALT:       state_nxt = HALT;
      // decode may keep presenting the finished opcode; wait for it to drop
      WAIT_CLEAR: if (!any_op) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // operate-instruction result; op7_q is one-hot whenever it is applied
  always_comb begin
    ac_n = ac;
    l_n  = link;
    skip = 1'b0;
    case (1'b1)
      op7_q.CLA1, op7_q.CLA2: ac_n = '0;
      op7_q.CLL:     l_n = 1'b0;
      op7_q.CLA_CLL: begin ac_n = '0; l_n = 1'b0; end
      op7_q.CMA:     ac_n = ~ac;
      op7_q.CML:     l_n = ~link;
      op7_q.CIA:     ac_n = -ac;
      op7_q.IAC:     begin ac_n = iac_sum[DATA_W-1:0]; l_n = link ^ iac_sum[DATA_W]; end
      op7_q.RAR:     {l_n, ac_n} = {ac[0], link, ac[DATA_W-1:1]};
      op7_q.RAL:     {l_n, ac_n} = {ac, link};
      op7_q.RTR:     {l_n, ac_n} = {ac[1:0], link, ac[DATA_W-1:2]};
      op7_q.RTL:     {l_n, ac_n} = {ac[DATA_W-2:0], link, ac[DATA_W-1]};
      op7_q.SPA:     skip = !ac[DATA_W-1];
      op7_q.SMA:     skip = ac[DATA_W-1];
      op7_q.SNA:     skip = |ac;
      op7_q.SZA:     skip = ~|ac;
      op7_q.SZL:     skip = !link;
      op7_q.SNL:     skip = link;
      op7_q.SKP:     skip = 1'b1;
      op7_q.OSR, op7_q.NOP, op7_q.HLT: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= base_addr;
      ac        <= '0;
      link      <= 1'b0;
      halted    <= 1'b0;
      mem_q     <= '0;
      op7_q     <= '0;
      illegal_q <= 1'b0;
      wdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_op) begin
          mem_q     <= pdp_mem_opcode;
          op7_q     <= pdp_op7_opcode;
          illegal_q <= multi_op;
          wdata     <= pdp_mem_opcode.JMS ? pc_inc : ac;
        end
        USE: begin
          if (mem_q.ISZ) wdata <= mem_rd_data + DATA_W'(1);
          else begin
            pc <= pc_inc;
            if (mem_q.AND) ac <= ac & mem_rd_data;
            else begin
              ac   <= tad_sum[DATA_W-1:0];
              link <= link ^ tad_sum[DATA_W];
            end
          end
        end
        WR: begin
          if (mem_q.ISZ)      pc <= (wdata == '0) ? pc_skip : pc_inc;
          else if (mem_q.JMS) pc <= mem_q.addr + ADDR_W'(1);
          else begin
            ac <= '0;
            pc <= pc_inc;
          end
        end
        EXEC: begin
          if (illegal_q)      pc <= pc_inc;
          else if (mem_q.JMP) pc <= mem_q.addr;
          else begin
            ac   <= ac_n;
            link <= l_n;
            pc   <= skip ? pc_skip : pc_inc;
            if (op7_q.HLT) halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_exec.sv
// Scoreboard bench for instr_exec: stimulus pushes expected reads, writes and
// retirement state; a negedge monitor pops and compares as the DUT produces them.
module tb_instr_exec;
  import instr_exec_pkg::*;

  localparam int B_CLA2 = 0, B_SPA = 1, B_SMA = 2, B_SNA = 3, B_SZA = 4, B_SZL = 5,
                 B_SNL = 6, B_SKP = 7, B_OSR = 8, B_HLT = 9, B_CLA_CLL = 10,
                 B_CLA1 = 11, B_CLL = 12, B_CIA = 13, B_CMA = 14, B_CML = 15,
                 B_RTR = 16, B_RAR = 17, B_RTL = 18, B_RAL = 19, B_IAC = 20, B_NOP = 21;
  localparam int M_JMP = 0, M_JMS = 1, M_DCA = 2, M_ISZ = 3, M_TAD = 4, M_AND = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [11:0]     base_addr = 12'o200;
  pdp_mem_opcode_s mem_op;
  pdp_op7_opcode_s op7;
  logic            stall, mem_rd_req, mem_wr_req, link_value, halted, illegal_op;
  logic [11:0]     PC_value, mem_rd_addr, mem_wr_addr, mem_wr_data, ac_value;
  logic [11:0]     mem_rd_data;

  always #5 clk = ~clk;

  instr_exec dut (
    .clk(clk), .reset(reset), .base_addr(base_addr),
    .pdp_mem_opcode(mem_op), .pdp_op7_opcode(op7),
    .stall(stall), .PC_value(PC_value),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .ac_value(ac_value), .link_value(link_value), .halted(halted), .illegal_op(illegal_op)
  );

  typedef struct { logic [11:0] addr; logic [11:0] data; } wr_t;
  typedef struct { logic [11:0] pc; logic [11:0] ac; logic l; } ret_t;

  wr_t         wr_q[$];
  logic [11:0] rd_q[$];
  ret_t        ret_q[$];
  int          n_chk = 0, n_err = 0, ill_cnt = 0;
  logic        prev_stall = 1'b0;
  bit          mem_load = 1'b1;
  logic [11:0] mem [0:4095];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // memory model: read data one cycle after the strobe
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 12'o0;
      mem[12'o5]  <= 12'o17;
      mem[12'o6]  <= 12'o7777;
      mem[12'o7]  <= 12'o1;
      mem[12'o16] <= 12'o3;
      mem[12'o17] <= 12'o5;
    end else begin
      if (mem_rd_req) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_req) mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_req) begin
        if (rd_q.size() == 0) fail("unexpected mem_rd_req");
        else chk("rd_addr", mem_rd_addr, rd_q.pop_front());
      end
      if (mem_wr_req) begin
        if (wr_q.size() == 0) fail("unexpected mem_wr_req");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", mem_wr_addr, w.addr);
          chk("wr_data", mem_wr_data, w.data);
        end
      end
      if (illegal_op) ill_cnt++;
      if (prev_stall && !stall) begin
        if (ret_q.size() == 0) fail("unexpected retirement");
        else begin
          ret_t r;
          r = ret_q.pop_front();
          chk("ret_pc", PC_value, r.pc);
          chk("ret_ac", ac_value, r.ac);
          chk("ret_link", link_value, r.l);
        end
      end
    end
    prev_stall <= stall;
  end

  function automatic pdp_mem_opcode_s mop(input int b, input logic [11:0] a);
    pdp_mem_opcode_s m;
    m = '0;
    m[12+b] = 1'b1;
    m.addr = a;
    return m;
  endfunction

  function automatic pdp_op7_opcode_s oop(input int b);
    pdp_op7_opcode_s o;
    o = '0;
    o[b] = 1'b1;
    return o;
  endfunction

  task automatic exp_ret(input logic [11:0] pc, input logic [11:0] ac, input logic l);
    ret_t r;
    r.pc = pc; r.ac = ac; r.l = l;
    ret_q.push_back(r);
  endtask

  task automatic exp_wr(input logic [11:0] a, input logic [11:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wr_q.push_back(w);
  endtask

  // present an opcode, measure accept-to-stall-low latency, then hold it two
  // more cycles the way decode does before clearing
  task automatic run(input string name, input pdp_mem_opcode_s mo, input pdp_op7_opcode_s oo,
                     input int lat);
    int n;
    @(negedge clk);
    mem_op = mo;
    op7    = oo;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (stall && n < 20);
    chk({name, " latency"}, n, lat);
    repeat (2) @(negedge clk);
    mem_op = '0;
    op7    = '0;
  endtask

  task automatic do_reset(input logic [11:0] b);
    @(negedge clk);
    reset     = 1'b1;
    base_addr = b;
    mem_op    = '0;
    op7       = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    mem_op = '0;
    op7    = '0;
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    chk("reset pc", PC_value, 12'o200);
    chk("reset ac", ac_value, 12'o0);
    chk("reset link", link_value, 1'b0);
    chk("reset stall", stall, 1'b0);
    chk("reset rd_req", mem_rd_req, 1'b0);
    chk("reset wr_req", mem_wr_req, 1'b0);
    chk("reset halted", halted, 1'b0);
    chk("reset illegal", illegal_op, 1'b0);
    reset = 1'b0;

    rd_q.push_back(12'o5);  exp_ret(12'o201, 12'o17, 1'b0);  run("TAD 5", mop(M_TAD, 12'o5), '0, 3);
    exp_ret(12'o202, 12'o0, 1'b0);    run("CLA1", '0, oop(B_CLA1), 2);
    exp_ret(12'o203, 12'o7777, 1'b0); run("CMA", '0, oop(B_CMA), 2);
    rd_q.push_back(12'o7);  exp_ret(12'o204, 12'o0, 1'b1);   run("TAD 7", mop(M_TAD, 12'o7), '0, 3);
    exp_ret(12'o206, 12'o0, 1'b1);    run("SZA", '0, oop(B_SZA), 2);
    rd_q.push_back(12'o6);  exp_wr(12'o6, 12'o0);  exp_ret(12'o210, 12'o0, 1'b1);
    run("ISZ 6", mop(M_ISZ, 12'o6), '0, 4);
    rd_q.push_back(12'o16); exp_wr(12'o16, 12'o4); exp_ret(12'o211, 12'o0, 1'b1);
    run("ISZ 16", mop(M_ISZ, 12'o16), '0, 4);

    do_reset(12'o200);
    exp_wr(12'o10, 12'o201); exp_ret(12'o11, 12'o0, 1'b0);   run("JMS 10", mop(M_JMS, 12'o10), '0, 2);
    exp_ret(12'o12, 12'o0, 1'b0);     run("JMP 12", mop(M_JMP, 12'o12), '0, 2);
    exp_ret(12'o13, 12'o7777, 1'b0);  run("CMA", '0, oop(B_CMA), 2);
    exp_wr(12'o20, 12'o7777); exp_ret(12'o14, 12'o0, 1'b0);  run("DCA 20", mop(M_DCA, 12'o20), '0, 2);
    exp_ret(12'o15, 12'o0, 1'b1);     run("CML", '0, oop(B_CML), 2);
    exp_ret(12'o16, 12'o1, 1'b0);     run("RAL", '0, oop(B_RAL), 2);
    exp_ret(12'o17, 12'o4000, 1'b0);  run("RTR", '0, oop(B_RTR), 2);
    exp_ret(12'o21, 12'o4000, 1'b0);  run("SMA", '0, oop(B_SMA), 2);
    exp_ret(12'o22, 12'o3777, 1'b0);  run("CMA", '0, oop(B_CMA), 2);
    exp_ret(12'o23, 12'o4000, 1'b0);  run("IAC", '0, oop(B_IAC), 2);
    exp_ret(12'o24, 12'o4000, 1'b0);  run("SNL", '0, oop(B_SNL), 2);
    exp_ret(12'o25, 12'o2000, 1'b0);  run("RAR", '0, oop(B_RAR), 2);
    exp_ret(12'o26, 12'o6000, 1'b0);  run("CIA", '0, oop(B_CIA), 2);

    // reset lands while ISZ is in USE: the write must never appear
    @(negedge clk);
    mem_op = mop(M_ISZ, 12'o17);
    rd_q.push_back(12'o17);
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    base_addr = 12'o300;
    mem_op    = '0;
    @(negedge clk);
    chk("abort pc", PC_value, 12'o300);
    chk("abort stall", stall, 1'b0);
    chk("abort wr_req", mem_wr_req, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort mem17", mem[12'o17], 12'o5);

    exp_ret(12'o301, 12'o7777, 1'b0); run("CMA", '0, oop(B_CMA), 2);
    exp_ret(12'o302, 12'o7777, 1'b0); run("illegal", mop(M_AND, 12'o5), oop(B_CLA1), 2);
    chk("illegal pulses", ill_cnt, 1);

    do_reset(12'o7777);
    exp_ret(12'o0, 12'o0, 1'b0);      run("NOP wrap", '0, oop(B_NOP), 2);

    @(negedge clk);
    op7 = oop(B_HLT);
    repeat (4) @(negedge clk);
    op7 = '0;
    repeat (4) @(negedge clk);
    chk("hlt halted", halted, 1'b1);
    chk("hlt stall", stall, 1'b1);
    chk("hlt pc", PC_value, 12'o1);

    chk("rd_q drained", rd_q.size(), 0);
    chk("wr_q drained", wr_q.size(), 0);
    chk("ret_q drained", ret_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
